prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: streams a program image into the core's instruction memory,
//   then holds the core in reset for HOLD_CYCLES cycles and releases it.
// Ports: i_clk, i_reset (sync active-low), i_start, i_in_valid/o_in_ready/
//   i_in_data/i_in_last (word stream), o_mem_we/o_mem_addr/o_mem_wdata
//   (registered memory write port), o_core_reset, o_done, o_full, o_err,
//   o_words_loaded.
// Optional feature macro: LOADER_CSUM_EN. When it is defined, the in_last
//   word is an XOR checksum of the image rather than an image word.
module prog_loader #(
  parameter int ADDR_W      = 10,
  parameter int HOLD_CYCLES = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [31:0]       i_in_data,
  input  logic              i_in_last,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_reset,
  output logic              o_done,
  output logic              o_full,
  output logic              o_err,
  output logic [ADDR_W:0]   o_words_loaded
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [7:0]      HOLD_INIT = 8'(HOLD_CYCLES);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_words;
  logic [7:0]        r_hold;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_full;
`ifdef LOADER_CSUM_EN
  logic [31:0]       r_csum;
  logic              r_err;
`endif

  logic w_xfer;
  logic w_csum_word;
  logic w_write;
  logic w_top;

  // A start in the same cycle as a handshake restarts the load; the offered
  // word is dropped rather than written to the old image.
  assign w_xfer = (r_state == ST_LOAD) && i_in_valid && !i_start;
`ifdef LOADER_CSUM_EN
  assign w_csum_word = i_in_last;
`else
  assign w_csum_word = 1'b0;
`endif
  assign w_write = w_xfer && !w_csum_word;
  assign w_top   = (r_addr == {ADDR_W{1'b1}});

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_words     <= '0;
      r_hold      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_full      <= 1'b0;
`ifdef LOADER_CSUM_EN
      r_csum      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      // Write port pulses for exactly one cycle per accepted image word.
      r_mem_we <= w_write;
      if (w_write) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= i_in_data;
        r_addr      <= r_addr + 1'b1;
        if (r_words != WORDS_MAX) r_words <= r_words + 1'b1;
`ifdef LOADER_CSUM_EN
        r_csum      <= r_csum ^ i_in_data;
`endif
      end

      if (i_start) begin
        r_state <= ST_LOAD;
        r_addr  <= '0;
        r_words <= '0;
        r_hold  <= '0;
        r_full  <= 1'b0;
`ifdef LOADER_CSUM_EN
        r_csum  <= '0;
        r_err   <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_LOAD: begin
            if (w_xfer) begin
              if (w_csum_word) begin
`ifdef LOADER_CSUM_EN
                if (i_in_data == r_csum) begin
                  r_state <= ST_HOLD;
                  r_hold  <= HOLD_INIT;
                end else begin
                  r_state <= ST_ERR;
                  r_err   <= 1'b1;
                end
`endif
              end else if (i_in_last || w_top) begin
                // Writing the top address fills memory whether or not the
                // word was also marked last.
                r_state <= ST_HOLD;
                r_hold  <= HOLD_INIT;
                r_full  <= w_top;
              end
            end
          end
          ST_HOLD: begin
            r_hold <= r_hold - 1'b1;
            if (r_hold <= 8'd1) r_state <= ST_RUN;
          end
          ST_RUN:  r_state <= ST_RUN;
          ST_ERR:  r_state <= ST_ERR;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_in_ready     = (r_state == ST_LOAD);
  assign o_core_reset   = (r_state != ST_RUN);
  assign o_done         = (r_state == ST_RUN);
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_full         = r_full;
  assign o_words_loaded = r_words;
`ifdef LOADER_CSUM_EN
  assign o_err          = r_err;
`else
  assign o_err          = 1'b0;
`endif

endmodule
